byte_serializer: RTL and testbench

BYTE_SERIALIZER -- requirements
Module: byte_serializer

---
 rtl/byte_serializer_if.sv | 33 +++
 rtl/byte_serializer.sv | 106 ++++++++++
 tb/tb_byte_serializer.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/byte_serializer_if.sv
// Parallel-in / serial-out bundle: word handshake on one side,
// framed bit stream on the other.
interface byte_serializer_if #(
    parameter int WIDTH = 8
) ();
    logic [WIDTH-1:0] data_in;
    logic             load_valid;
    logic             load_ready;
    logic             bit_out;
    logic             bit_valid;
    logic             frame_start;
    logic             busy;

    modport master (
        output data_in,
        output load_valid,
        input  load_ready,
        input  bit_out,
        input  bit_valid,
        input  frame_start,
        input  busy
    );

    modport slave (
        input  data_in,
        input  load_valid,
        output load_ready,
        output bit_out,
        output bit_valid,
        output frame_start,
        output busy
    );
endinterface

// File: rtl/byte_serializer.sv
// Word-to-bit serializer with a one-word skid buffer so that
// back-to-back words stream out without idle cycles.
module byte_serializer #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    byte_serializer_if.slave bus
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t           state_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] sh_q;
    logic [WIDTH-1:0] hold_q;
    logic             hold_full_q;
    logic             bit_out_q;
    logic             bit_valid_q;
    logic             frame_q;

    logic             hs;
    logic             last;
    logic [WIDTH-1:0] sh_d;

    function automatic logic head(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? w[WIDTH-1] : w[0];
    endfunction

    // The bit currently on the wire always sits at the head end of sh_q.
    assign sh_d = MSB_FIRST ? {sh_q[WIDTH-2:0], 1'b0}
                            : {1'b0, sh_q[WIDTH-1:1]};

    assign bus.load_ready  = ~hold_full_q & ~rst;
    assign bus.bit_out     = bit_out_q;
    assign bus.bit_valid   = bit_valid_q;
    assign bus.frame_start = frame_q;
    assign bus.busy        = bit_valid_q | hold_full_q;

    assign hs   = bus.load_valid & bus.load_ready;
    assign last = (cnt_q == CW'(WIDTH - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            sh_q        <= '0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            bit_out_q   <= 1'b0;
            bit_valid_q <= 1'b0;
            frame_q     <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (hs) begin
                        state_q     <= SHIFT;
                        sh_q        <= bus.data_in;
                        cnt_q       <= '0;
                        bit_out_q   <= head(bus.data_in);
                        bit_valid_q <= 1'b1;
                        frame_q     <= 1'b1;
                    end
                end
                SHIFT: begin
                    if (!last) begin
                        sh_q      <= sh_d;
                        cnt_q     <= cnt_q + CW'(1);
                        bit_out_q <= head(sh_d);
                        frame_q   <= 1'b0;
                        if (hs) begin
                            hold_q      <= bus.data_in;
                            hold_full_q <= 1'b1;
                        end
                    end else if (hold_full_q) begin
                        sh_q        <= hold_q;
                        hold_full_q <= 1'b0;
                        cnt_q       <= '0;
                        bit_out_q   <= head(hold_q);
                        frame_q     <= 1'b1;
                    end else if (hs) begin
                        // Empty skid buffer: take the new word straight in.
                        sh_q      <= bus.data_in;
                        cnt_q     <= '0;
                        bit_out_q <= head(bus.data_in);
                        frame_q   <= 1'b1;
                    end else begin
                        state_q     <= IDLE;
                        sh_q        <= '0;
                        cnt_q       <= '0;
                        bit_out_q   <= 1'b0;
                        bit_valid_q <= 1'b0;
                        frame_q     <= 1'b0;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_byte_serializer.sv
// Bench for byte_serializer: WIDTH=4 MSB-first and WIDTH=8 LSB-first
// instances, scoreboard-checked bit streams plus handshake timing.
module tb_byte_serializer;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    byte_serializer_if #(.WIDTH(4)) ia ();
    byte_serializer_if #(.WIDTH(8)) ib ();

    byte_serializer #(.WIDTH(4), .MSB_FIRST(1'b1)) u_a (
        .clk (clk),
        .rst (rst),
        .bus (ia.slave)
    );

    byte_serializer #(.WIDTH(8), .MSB_FIRST(1'b0)) u_b (
        .clk (clk),
        .rst (rst),
        .bus (ib.slave)
    );

    typedef struct {
        logic b;
        logic fs;
    } exp_t;

    typedef struct {
        bit         sel;
        logic [7:0] data;
        logic [7:0] seq;
        int         gap;
    } vec_t;

    exp_t qa[$];
    exp_t qb[$];
    exp_t ea;
    exp_t eb;
    int   checks = 0;
    int   errors = 0;

    function automatic void chk(string name, logic [31:0] act,
                                logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endfunction

    task automatic push_a(input logic [3:0] seq);
        for (int i = 3; i >= 0; i--)
            qa.push_back('{b: seq[i], fs: (i == 3)});
    endtask

    task automatic push_b(input logic [7:0] seq);
        for (int i = 7; i >= 0; i--)
            qb.push_back('{b: seq[i], fs: (i == 7)});
    endtask

    // seq lists the expected wire bits left to right in send order.
    task automatic send_a(input logic [3:0] d, input logic [3:0] seq,
                          output int n);
        n = 0;
        @(negedge clk);
        ia.data_in    = d;
        ia.load_valid = 1'b1;
        while (!ia.load_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("a_send_ready", ia.load_ready, 1);
        if (ia.load_ready) push_a(seq);
        @(posedge clk);
        #1 ia.load_valid = 1'b0;
    endtask

    task automatic send_b(input logic [7:0] d, input logic [7:0] seq,
                          output int n);
        n = 0;
        @(negedge clk);
        ib.data_in    = d;
        ib.load_valid = 1'b1;
        while (!ib.load_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("b_send_ready", ib.load_ready, 1);
        if (ib.load_ready) push_b(seq);
        @(posedge clk);
        #1 ib.load_valid = 1'b0;
    endtask

    // Cycle i after acceptance: valid for i<=nv; ready low in [ra,rb]
    // and high at rb+1; ra<0 means ready must stay high throughout.
    task automatic win_a(input int nv, input int ra, input int rb);
        for (int i = 1; i <= nv + 1; i++) begin
            @(negedge clk);
            chk($sformatf("a_win_valid[%0d]", i), ia.bit_valid, (i <= nv));
            if (ra < 0)
                chk($sformatf("a_win_rdy1[%0d]", i), ia.load_ready, 1);
            else if (ra > 0 && i >= ra && i <= rb)
                chk($sformatf("a_win_rdy0[%0d]", i), ia.load_ready, 0);
            else if (ra > 0 && i == rb + 1)
                chk($sformatf("a_win_rdy1[%0d]", i), ia.load_ready, 1);
        end
    endtask

    task automatic drain();
        int t = 0;
        while ((qa.size() != 0 || qb.size() != 0 ||
                ia.bit_valid || ib.bit_valid) && t < 200) begin
            @(negedge clk);
            t++;
        end
        chk("drain_done", (t < 200), 1);
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (ia.bit_valid) begin
                if (qa.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL a_extra_bit: got bit %0b want none",
                             ia.bit_out);
                end else begin
                    ea = qa.pop_front();
                    chk("a_bit", ia.bit_out, ea.b);
                    chk("a_fs", ia.frame_start, ea.fs);
                    chk("a_busy", ia.busy, 1);
                end
            end else begin
                chk("a_idle_out", {ia.bit_out, ia.frame_start, ia.busy}, 0);
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (ib.bit_valid) begin
                if (qb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL b_extra_bit: got bit %0b want none",
                             ib.bit_out);
                end else begin
                    eb = qb.pop_front();
                    chk("b_bit", ib.bit_out, eb.b);
                    chk("b_fs", ib.frame_start, eb.fs);
                    chk("b_busy", ib.busy, 1);
                end
            end else begin
                chk("b_idle_out", {ib.bit_out, ib.frame_start, ib.busy}, 0);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vt[8];
        int   n;
        int   n2;

        vt[0] = '{1'b0, 8'h00, 8'h00, 0};
        vt[1] = '{1'b0, 8'h0F, 8'h0F, 0};
        vt[2] = '{1'b0, 8'h08, 8'h08, 0};
        vt[3] = '{1'b0, 8'h05, 8'h05, 3};
        vt[4] = '{1'b1, 8'h01, 8'b1000_0000, 2};
        vt[5] = '{1'b1, 8'hC8, 8'b0001_0011, 0};
        vt[6] = '{1'b1, 8'h3C, 8'b0011_1100, 0};
        vt[7] = '{1'b0, 8'h01, 8'h01, 1};

        ia.data_in    = '0;
        ia.load_valid = 1'b0;
        ib.data_in    = '0;
        ib.load_valid = 1'b0;

        #1;
        chk("rst_a_out", {ia.bit_out, ia.bit_valid, ia.frame_start}, 0);
        chk("rst_a_busy", ia.busy, 0);
        chk("rst_a_ready", ia.load_ready, 0);
        chk("rst_b_out", {ib.bit_out, ib.bit_valid, ib.frame_start}, 0);
        chk("rst_b_busy", ib.busy, 0);
        chk("rst_b_ready", ib.load_ready, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rel_a_ready", ia.load_ready, 1);
        chk("rel_b_ready", ib.load_ready, 1);

        // single word, idle afterwards
        send_a(4'b1011, 4'b1011, n);
        win_a(4, 0, 0);
        drain();

        // back-to-back through the hold register
        send_a(4'b1011, 4'b1011, n);
        fork
            begin
                @(negedge clk);
                send_a(4'b0110, 4'b0110, n2);
            end
            win_a(8, 3, 4);
        join
        drain();

        // direct reload on the last-bit edge
        send_a(4'b1111, 4'b1111, n);
        fork
            begin
                repeat (3) @(negedge clk);
                send_a(4'b0001, 4'b0001, n2);
            end
            win_a(8, -1, 0);
        join
        chk("a_direct_nowait", n2, 0);
        drain();

        // LSB-first
        send_b(8'hA5, 8'b1010_0101, n);
        drain();

        // backpressure with hold full and valid held high
        send_a(4'b1011, 4'b1011, n);
        send_a(4'b0110, 4'b0110, n);
        send_a(4'b1001, 4'b1001, n);
        chk("a_backpressure_wait", n, 3);
        drain();

        for (int i = 0; i < 8; i++) begin
            repeat (vt[i].gap) @(negedge clk);
            if (vt[i].sel)
                send_b(vt[i].data, vt[i].seq, n);
            else
                send_a(vt[i].data[3:0], vt[i].seq[3:0], n);
        end
        drain();

        // reset during the 3rd bit with a word held
        send_a(4'b1011, 4'b1011, n);
        send_a(4'b0110, 4'b0110, n);
        @(negedge clk);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_out", {ia.bit_out, ia.bit_valid, ia.frame_start}, 0);
        chk("mid_rst_busy", ia.busy, 0);
        chk("mid_rst_ready", ia.load_ready, 0);
        qa.delete();
        qb.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("post_rst_ready", ia.load_ready, 1);
        send_a(4'b0110, 4'b0110, n);
        win_a(4, 0, 0);
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
